// File: rtl/sram_write_demux_if.sv
// ---------------------------------------------------------------------------
// sram_write_demux_if
//
// Purpose:
//   Bundles the burst-request, beat-stream and SRAM bank-write signals of the
//   SRAM write demux into a single interface.
//
// Signals:
//   start        : burst request, sampled only while busy = 0
//   base_addr    : burst start byte address (low offset bits ignored)
//   in_valid     : data beat valid
//   in_data      : data beat, byte 0 in bits [7:0]
//   in_last      : final beat of the burst
//   in_num_valid : valid bytes in the last beat, 0 means all bytes
//   in_ready     : demux can accept a beat this cycle
//   busy         : burst in progress
//   done         : one-cycle pulse coinciding with the last bank write
//   bank_we      : one-hot bank write enable
//   bank_row     : row address within the selected bank
//   bank_wdata   : write data, broadcast to all banks
//   bank_be      : byte enables of the write
//   beat_count   : beats written in the current or most recent burst
//
// Handshake:
//   A beat transfers on a rising clk edge where in_valid && in_ready are both
//   high. in_ready never depends combinationally on in_valid. The source may
//   raise or drop in_valid freely, and a beat offered while in_ready = 0 is
//   simply not taken. start is a level that is acted on only while busy = 0.
//
// Modports:
//   master : the burst source (memory controller / bench) side
//   slave  : the demux side
// ---------------------------------------------------------------------------
interface sram_write_demux_if #(
    parameter int NUM_BANKS  = 16,
    parameter int ADDR_W     = 19,
    parameter int BEAT_BYTES = 16,
    parameter int CNT_W      = 16
);
    localparam int OFF_W  = $clog2(BEAT_BYTES);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - OFF_W - BANK_W;
    localparam int DATA_W = 8 * BEAT_BYTES;

    // Burst request
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;

    // Beat stream
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_last;
    logic [OFF_W-1:0]      in_num_valid;
    logic                  in_ready;

    // Status
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      beat_count;

    // Bank write port
    logic [NUM_BANKS-1:0]  bank_we;
    logic [ROW_W-1:0]      bank_row;
    logic [DATA_W-1:0]     bank_wdata;
    logic [BEAT_BYTES-1:0] bank_be;

    modport master (
        output start,
        output base_addr,
        output in_valid,
        output in_data,
        output in_last,
        output in_num_valid,
        input  in_ready,
        input  busy,
        input  done,
        input  beat_count,
        input  bank_we,
        input  bank_row,
        input  bank_wdata,
        input  bank_be
    );

    modport slave (
        input  start,
        input  base_addr,
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_num_valid,
        output in_ready,
        output busy,
        output done,
        output beat_count,
        output bank_we,
        output bank_row,
        output bank_wdata,
        output bank_be
    );
endinterface

// File: rtl/sram_write_demux.sv
// ---------------------------------------------------------------------------
// sram_write_demux
//
// Purpose:
//   Downstream stage of the memory controller. Takes a write-burst start
//   (beat-aligned SRAM byte address), then streams the following data beats
//   into NUM_BANKS word-interleaved SRAM banks, one registered bank write per
//   accepted beat. The last beat may be partial; its byte-enable mask keeps
//   only the low in_num_valid bytes.
//
//   Address split of a byte address:
//     word index = addr[ADDR_W-1:OFF_W]
//     bank       = word index[BANK_W-1:0]
//     row        = word index[WORD_W-1:BANK_W]
//   Consecutive beats therefore walk across the banks first, then rows,
//   wrapping from the last row of the last bank back to row 0 of bank 0.
//
// Ports:
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   bus         : sram_write_demux_if.slave (burst request, beat stream,
//                 status and bank write port)
//   o_dbg_state : current FSM state (0 = IDLE, 1 = STREAM, 2 = FLUSH)
//
// Timing:
//   start taken in IDLE -> STREAM on the next edge, beats accepted from then.
//   Accepted beat -> bank write visible one cycle later.
//   Last beat accepted -> FLUSH for exactly one cycle with done = 1, which is
//   the cycle the final bank write is on the outputs, then back to IDLE.
// ---------------------------------------------------------------------------
module sram_write_demux #(
    parameter int NUM_BANKS  = 16,
    parameter int ADDR_W     = 19,
    parameter int BEAT_BYTES = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_write_demux_if.slave    bus,
    output logic [1:0]           o_dbg_state
);

    localparam int OFF_W  = $clog2(BEAT_BYTES);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int ROW_W  = WORD_W - BANK_W;
    localparam int DATA_W = 8 * BEAT_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t                r_state;
    logic [WORD_W-1:0]     r_word_ptr;
    logic [CNT_W-1:0]      r_beat_count;
    logic [NUM_BANKS-1:0]  r_bank_we;
    logic [ROW_W-1:0]      r_bank_row;
    logic [DATA_W-1:0]     r_bank_wdata;
    logic [BEAT_BYTES-1:0] r_bank_be;
    logic                  r_done;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic                  w_accept;
    logic [BEAT_BYTES-1:0] w_beat_be;
    logic [NUM_BANKS-1:0]  w_bank_onehot;
    logic                  w_unused_base_bits;

    // Beat-aligned bursts: the byte offset inside a beat carries no meaning.
    assign w_unused_base_bits = ^bus.base_addr[OFF_W-1:0];

    // in_ready is a pure decode of the state register, so acceptance never
    // loops back through in_valid.
    assign w_accept = bus.in_valid && (r_state == ST_STREAM);

    assign w_bank_onehot = NUM_BANKS'(1) << r_word_ptr[BANK_W-1:0];

    // Full mask for every beat except a last beat with a non-zero byte count,
    // which keeps only its low in_num_valid bytes.
    always_comb begin
        w_beat_be = '1;
        if (bus.in_last && (bus.in_num_valid != '0)) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                w_beat_be[b] = (b < int'(bus.in_num_valid));
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM with registered bank-write outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_word_ptr   <= '0;
            r_beat_count <= '0;
            r_bank_we    <= '0;
            r_bank_row   <= '0;
            r_bank_wdata <= '0;
            r_bank_be    <= '0;
            r_done       <= 1'b0;
        end else begin
            // Write strobe and done are single-cycle pulses; row, data and
            // byte enables keep their last values between writes.
            r_bank_we <= '0;
            r_done    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Beats offered here, even alongside start, are dropped.
                    if (bus.start) begin
                        r_word_ptr   <= bus.base_addr[ADDR_W-1:OFF_W];
                        r_beat_count <= '0;
                        r_state      <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    // start is ignored while a burst is in progress.
                    if (w_accept) begin
                        r_bank_we    <= w_bank_onehot;
                        r_bank_row   <= r_word_ptr[WORD_W-1:BANK_W];
                        r_bank_wdata <= bus.in_data;
                        r_bank_be    <= w_beat_be;
                        // Wraps naturally across the whole bank/row space.
                        r_word_ptr   <= r_word_ptr + WORD_W'(1);
                        r_beat_count <= r_beat_count + CNT_W'(1);
                        if (bus.in_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.in_ready   = (r_state == ST_STREAM);
    assign bus.done       = r_done;
    assign bus.beat_count = r_beat_count;
    assign bus.bank_we    = r_bank_we;
    assign bus.bank_row   = r_bank_row;
    assign bus.bank_wdata = r_bank_wdata;
    assign bus.bank_be    = r_bank_be;

    assign o_dbg_state    = r_state;

endmodule
